// File: rtl/custom_run_search_pkg.sv
// custom_run_search_pkg
// Shared definitions for the run search unit: the scan FSM state encoding
// and the bit positions of the per-scan mode field.
package custom_run_search_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        FINAL,
        DONE
    } state_e;

    // mode[MODE_INC_BIT]       : 0 = decreasing runs, 1 = increasing runs
    // mode[MODE_NONSTRICT_BIT] : 0 = strict, 1 = equal elements continue a run
    localparam int MODE_INC_BIT       = 0;
    localparam int MODE_NONSTRICT_BIT = 1;

endpackage

// File: rtl/custom_run_search_unit_tracker.sv
// custom_run_tracker
// Consumes one signed element per valid cycle and tracks the current
// monotonic run and the best (longest, latest on ties) run seen so far.
//
// Ports:
//   clock, resetn  : clock, asynchronous active-low reset
//   valid          : an element is presented on data this cycle
//   first          : the presented element is index 0 of the scan
//   index          : array index of the presented element
//   data           : the element (two's complement)
//   mode           : direction / strictness select (see package)
//   close          : fold the open run into the best result
//   res_start      : start index of the best run including the open run
//   res_len        : length of the best run including the open run
module custom_run_tracker
    import custom_run_search_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              valid,
    input  logic              first,
    input  logic [ADDR_W-1:0] index,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    input  logic              close,
    output logic [ADDR_W-1:0] res_start,
    output logic [ADDR_W:0]   res_len
);

    logic signed [DATA_W-1:0] data_s;
    logic signed [DATA_W-1:0] prev_q, prev_d;
    logic [ADDR_W:0]          cur_len_q, cur_len_d;
    logic [ADDR_W-1:0]        cur_start_q, cur_start_d;
    logic [ADDR_W:0]          best_len_q, best_len_d;
    logic [ADDR_W-1:0]        best_start_q, best_start_d;
    logic                     rel_ok;
    logic                     take_cur;

    assign data_s = $signed(data);

    // Relation of the new element against its predecessor, signed compare.
    always_comb begin
        rel_ok = 1'b0;
        if (mode[MODE_INC_BIT]) begin
            rel_ok = mode[MODE_NONSTRICT_BIT] ? (data_s >= prev_q) : (data_s > prev_q);
        end else begin
            rel_ok = mode[MODE_NONSTRICT_BIT] ? (data_s <= prev_q) : (data_s < prev_q);
        end
    end

    // ">=" makes the latest of equally long runs win.
    assign take_cur  = (cur_len_q >= best_len_q);
    assign res_len   = take_cur ? cur_len_q : best_len_q;
    assign res_start = take_cur ? cur_start_q : best_start_q;

    always_comb begin
        prev_d       = prev_q;
        cur_len_d    = cur_len_q;
        cur_start_d  = cur_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;

        if (valid) begin
            prev_d = data_s;
            if (first) begin
                // Index 0 opens a fresh scan; earlier results are discarded.
                cur_len_d    = (ADDR_W+1)'(1);
                cur_start_d  = index;
                best_len_d   = '0;
                best_start_d = '0;
            end else if (rel_ok) begin
                cur_len_d = cur_len_q + (ADDR_W+1)'(1);
            end else begin
                if (take_cur) begin
                    best_len_d   = cur_len_q;
                    best_start_d = cur_start_q;
                end
                cur_len_d   = (ADDR_W+1)'(1);
                cur_start_d = index;
            end
        end else if (close) begin
            if (take_cur) begin
                best_len_d   = cur_len_q;
                best_start_d = cur_start_q;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev_q       <= '0;
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
        end else begin
            prev_q       <= prev_d;
            cur_len_q    <= cur_len_d;
            cur_start_q  <= cur_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
        end
    end

endmodule

// File: rtl/custom_run_search_unit.sv
// custom_run_search_unit
// Streams DEPTH signed elements from a synchronous-read RAM with RD_LAT
// cycles of read latency and reports the longest monotonic run.
//
// Ports:
//   clock, resetn : clock, asynchronous active-low reset
//   start         : level request, sampled only while idle
//   mode          : bit0 increasing, bit1 non-strict; latched on start
//   rd_data       : RAM read data
//   rd_address    : RAM read address
//   seq_address   : first index of the longest run
//   length        : element count of the longest run
//   busy          : scan in progress
//   done          : one-cycle pulse when seq_address/length are valid
module custom_run_search_unit
    import custom_run_search_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_address,
    output logic [ADDR_W-1:0] seq_address,
    output logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cons_q, cons_d;
    logic [1:0]        mode_q, mode_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [ADDR_W-1:0] seq_q, seq_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              consume;
    logic              close;
    logic [ADDR_W-1:0] res_start;
    logic [ADDR_W:0]   res_len;

    // Oldest stage of the valid pipeline lines up with rd_data.
    assign consume = vld_q[RD_LAT-1];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cons_d  = cons_q;
        mode_d  = mode_q;
        seq_d   = seq_q;
        len_d   = len_q;
        busy_d  = busy_q;
        done_d  = done_q;
        close   = 1'b0;

        // One valid token per address issued while fetching.
        vld_d[0] = (state_q == FETCH);
        for (int k = 1; k < RD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
        end

        if (consume && (cons_q != LAST_IDX)) begin
            cons_d = cons_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                addr_d = '0;
                done_d = 1'b0;
                if (start) begin
                    mode_d  = mode;
                    seq_d   = '0;
                    len_d   = '0;
                    busy_d  = 1'b1;
                    cons_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Address saturates at the last element, never wraps.
                if (addr_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (consume && (cons_q == LAST_IDX)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                // Result includes the still-open run via the tracker's
                // combinational view; the tracker folds it in as well.
                close   = 1'b1;
                seq_d   = res_start;
                len_d   = res_len;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b0;
                addr_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cons_q  <= '0;
            mode_q  <= '0;
            vld_q   <= '0;
            seq_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cons_q  <= cons_d;
            mode_q  <= mode_d;
            vld_q   <= vld_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    custom_run_tracker #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_tracker (
        .clock     (clock),
        .resetn    (resetn),
        .valid     (consume),
        .first     (cons_q == '0),
        .index     (cons_q),
        .data      (rd_data),
        .mode      (mode_q),
        .close     (close),
        .res_start (res_start),
        .res_len   (res_len)
    );

    assign rd_address  = addr_q;
    assign seq_address = seq_q;
    assign length      = len_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
